// File: rtl/keypad_pkg.sv
// Shared constants, scan-state encoding and key-decoding helpers for the
// 4x3 keypad scanner and its debouncer.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_MULTI = 4'hE;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } scan_state_t;

  // Snapshot bit index is col*4 + row; col0 is the left column.
  function automatic logic [3:0] key_of_index(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd4;
      4'd2:    code = 4'd7;
      4'd3:    code = KEY_STAR;
      4'd4:    code = 4'd2;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd8;
      4'd7:    code = 4'd0;
      4'd8:    code = 4'd3;
      4'd9:    code = 4'd6;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] raw_decode(input logic [11:0] vec);
    logic [3:0] code;
    logic [3:0] hits;
    code = KEY_NONE;
    hits = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (vec[i]) begin
        hits = hits + 4'd1;
        code = key_of_index(4'(i));
      end
    end
    if (hits > 4'd1) code = KEY_MULTI;
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Accepts a scanned key code only after DEB_SCANS identical consecutive scans;
// flags acceptance of a new valid key with a one-cycle registered strobe.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_done,
  input  logic [3:0] raw,
  output logic [3:0] stable,
  output logic       new_key
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_SCANS);

  logic [3:0] r_cand;
  logic [3:0] r_cnt;
  logic [3:0] r_stable;
  logic       r_new_key;
  logic [3:0] w_cand_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_accept;

  // Acceptance looks at the post-update count so DEB_SCANS=1 accepts on the first scan.
  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (scan_done) begin
      if (raw == r_cand) begin
        w_cnt_nxt = (r_cnt == DEB_MAX) ? r_cnt : r_cnt + 4'd1;
      end else begin
        w_cand_nxt = raw;
        w_cnt_nxt  = 4'd1;
      end
    end
    w_accept = scan_done && (w_cnt_nxt == DEB_MAX) && (w_cand_nxt != r_stable);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand    <= KEY_NONE;
      r_cnt     <= 4'd0;
      r_stable  <= KEY_NONE;
      r_new_key <= 1'b0;
    end else begin
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_new_key <= w_accept && (w_cand_nxt <= KEY_HASH);
      if (w_accept) r_stable <= w_cand_nxt;
    end
  end

  assign stable  = r_stable;
  assign new_key = r_new_key;

endmodule

// File: rtl/keypad_scan.sv
// Column-scanning 4x3 keypad front end: drives one column low at a time,
// samples the rows, debounces full scans and decodes the accepted key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 1,
  parameter int DEB_SCANS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic [3:0] key_code,
  output logic       key_pulse
);

  scan_state_t r_state;
  scan_state_t w_state_nxt;
  logic [3:0]  r_tick;
  // Only columns 0 and 1 are held; column 2 is used live at scan completion.
  logic [7:0]  r_snap;
  logic        w_last;
  logic        w_scan_done;
  logic [11:0] w_vec;
  logic [3:0]  w_raw;
  logic [3:0]  w_stable;
  logic        w_new_key;

  assign w_last      = (r_tick == 4'(SCAN_TICKS - 1));
  assign w_scan_done = (r_state == COL2) && w_last;
  assign w_vec       = {~key_row, r_snap};
  assign w_raw       = raw_decode(w_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COL0;
      r_tick  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_last ? 4'd0 : r_tick + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_last) begin
      case (r_state)
        COL0:    w_state_nxt = COL1;
        COL1:    w_state_nxt = COL2;
        default: w_state_nxt = COL0;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      COL0:    key_col = 3'b110;
      COL1:    key_col = 3'b101;
      COL2:    key_col = 3'b011;
      default: key_col = 3'b110;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= 8'd0;
    end else if (w_last) begin
      if (r_state == COL0) r_snap[3:0] <= ~key_row;
      if (r_state == COL1) r_snap[7:4] <= ~key_row;
    end
  end

  keypad_debounce #(
    .DEB_SCANS(DEB_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .scan_done(w_scan_done),
    .raw      (w_raw),
    .stable   (w_stable),
    .new_key  (w_new_key)
  );

  // Stable is a register, so these decodes change only at the acceptance edge.
  always_comb begin
    keypad   = 10'd0;
    key_star = 1'b0;
    key_hash = 1'b0;
    key_code = KEY_NONE;
    if (w_stable <= 4'd9) begin
      keypad   = 10'd1 << w_stable;
      key_code = w_stable;
    end else if (w_stable == KEY_STAR) begin
      key_star = 1'b1;
      key_code = KEY_STAR;
    end else if (w_stable == KEY_HASH) begin
      key_hash = 1'b1;
      key_code = KEY_HASH;
    end
  end

  assign key_pulse = w_new_key;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4-row x 3-column membrane keypad and debounces the result.
- Produces the 10-bit one-hot `keypad` bus consumed by the watch and timer blocks, plus a key code and a new-press pulse.
- Sits on the input side of the top-level mode controller, between the board keypad pins and the application modules.
- Runs on the 1 kHz system clock.

Parameters:
- SCAN_TICKS, 1, clk cycles each column is driven before its rows are sampled (1..15).
- DEB_SCANS, 3, consecutive identical full scans required to accept a press or release (1..15).

Ports:
- clk  input  1  system clock (1 kHz)
- rst  input  1  reset, asynchronous, active-high
- key_row  input  4  row sense lines, active-low (externally pulled up)
- key_col  output  3  column drive lines, active-low, exactly one low at a time
- keypad  output  10  one-hot digit; bit n high while digit n is the accepted key
- key_star  output  1  high while '*' is the accepted key
- key_hash  output  1  high while '#' is the accepted key
- key_code  output  4  accepted key: 0-9 digits, 10 '*', 11 '#', 15 none
- key_pulse  output  1  one-cycle strobe on acceptance of a new valid key

Behaviour:
- Reset values:
  - key_col = 3'b110 (column 0 driven).
  - keypad = 0, key_star = 0, key_hash = 0, key_pulse = 0, key_code = 4'hF.
  - All counters = 0; snapshot, candidate and stable = NONE.
- Key map (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
  - col0 is the left column.
- Scan FSM, states COL0 -> COL1 -> COL2 -> COL0:
  - Each state drives its column low for SCAN_TICKS cycles; a tick counter runs 0..SCAN_TICKS-1.
  - On the tick where counter = SCAN_TICKS-1, the inverted key_row is captured into that column's 4 bits of a 12-bit snapshot, and the FSM advances.
  - A full scan therefore takes 3*SCAN_TICKS cycles.
- Scan completion (the COL2 sample edge):
  - raw is computed combinationally from the snapshot with the current COL2 rows substituted.
  - 0 bits set -> NONE (15).
  - Exactly 1 bit set -> that key's code.
  - 2 or more bits set -> MULTI (14, internal only; treated as no key at the outputs).
- Debounce, evaluated only at the scan-completion edge:
  - If raw == candidate: match_cnt increments, saturating at DEB_SCANS.
  - Otherwise: candidate <= raw, match_cnt <= 1.
  - When match_cnt reaches DEB_SCANS on this edge and candidate != stable: stable <= candidate.
- Output update:
  - Outputs are registered and updated at the same edge stable changes.
  - keypad, key_star, key_hash and key_code are decoded from stable; MULTI and NONE both give key_code = 15 and all indicators low.
- key_pulse:
  - High for exactly the one cycle following an edge where stable changes to a valid key (0-11).
  - No pulse on release (-> NONE), on change to MULTI, or while a key is held.
  - A change from one valid key directly to another valid key pulses.
- Latency:
  - A press that is stable from the start of a scan is accepted at the end of scan number DEB_SCANS.
  - With the defaults that is 9 cycles after the start of the first matching scan.
- Mid-scan changes: a row change affects only columns not yet sampled in the current scan; there is no rescan.
- Reset mid-operation: everything returns to reset values immediately; no pulse is generated for a key held through reset until it is re-accepted after DEB_SCANS scans.

Decomposition:
- Shared package keypad_pkg holds:
  - KEY_NONE = 4'hF, KEY_MULTI = 4'hE, KEY_STAR = 4'd10, KEY_HASH = 4'd11
  - Scan-state encodings COL0/COL1/COL2 = 2'd0/1/2
- One sub-module, keypad_debounce:
  - Inputs: clk, rst, scan_done, raw[3:0].
  - Outputs: stable[3:0], new_key.
- Scan FSM, snapshot and output decode remain in keypad_scan.

Test Plan:
- Reset: assert rst mid-scan -> key_col = 110, key_code = F, keypad = 0, key_pulse = 0 in the same cycle.
- Clean press '5' (r1 low while col1 low) with SCAN_TICKS=1, DEB_SCANS=3:
  - Response: after the 3rd full scan, key_code = 5 and keypad = 10'b0000100000.
  - key_pulse high for exactly 1 cycle, and no further pulse during a 50-cycle hold.
- Bounce: '7' present on alternate scans for 12 scans -> key_code stays F, no pulse. Then held 3 scans -> accepted as 7 with one pulse.
- Two keys, '1' and '9', held -> key_code = F, keypad = 0, no pulse. Release '9' -> '1' accepted after 3 scans with a pulse.
- '*' then '0' (direct change, no release between):
  - key_star = 1 with a pulse first.
  - Then key_star = 0, keypad[0] = 1, key_code = 0 with a second pulse.
- Release after '#' held:
  - key_hash stays 1 for 2 scans after release, then drops with key_code = F and no pulse.
  - Repeat with SCAN_TICKS=4: key_col holds each column for exactly 4 cycles.
